uart_rx_fifo: RTL and testbench

Oversampling UART receiver with an output FIFO: the receive end of the serial link driven by the team's UART transmitter. It synchronises the asynchronous `rx` line and validates the start bit mid-bit. It samples 8N1 frames LSB first, flags framing errors, and buffers received bytes behind a valid/ready handshake. Downstream logic can then drain bytes at its own pace.

---
 rtl/uart_rx_fifo_if.sv | 29 ++
 rtl/uart_rx_fifo.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver and its consumer: head byte, handshake, error pulses.
// Latency: none (wires only).
// Backpressure: consumer holds ready low; the receiver keeps the head byte stable until ready is high.
interface uart_rx_fifo_if;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output data_out,
    output valid,
    output frame_err,
    output overrun,
    output parity_err,
    input  ready
  );

  modport slave (
    input  data_out,
    input  valid,
    input  frame_err,
    input  overrun,
    input  parity_err,
    output ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver with a FIFO_DEPTH-entry byte FIFO on a valid/ready output.
// Latency: byte visible (valid) one cycle after the mid-stop-bit sample; error pulses in that same cycle.
// Backpressure: ready low holds bytes in the FIFO; a good byte arriving while full is dropped with an overrun pulse.
// Optional even-parity frame support is built when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_fifo_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY    = 3'd5
`endif
  } state_t;

  logic          rx_m;
  logic          rx_s;
  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;

  logic          at_mid;
  logic          at_end;
  logic          push_req;
  logic          fe_req;
  logic          pe_req;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          ovr_req;

  logic          frame_err_q;
  logic          overrun_q;

  assign at_mid = (cnt == CNT_MID);
  assign at_end = (cnt == CNT_END);

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!rx_s) state_nx = START;
      START:     if (at_mid) state_nx = rx_s ? IDLE : DATA;
      DATA: begin
        if (at_end && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (at_end) state_nx = STOP;
`endif
      STOP:      if (at_end) state_nx = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // FSM outputs: frame outcome strobes, all decided at the mid-stop-bit sample.
  always_comb begin
    push_req = 1'b0;
    fe_req   = 1'b0;
    pe_req   = 1'b0;
    if (state == STOP && at_end) begin
      push_req = rx_s && !par_bad;
      fe_req   = !rx_s;
      pe_req   = par_bad;
    end
  end

  // Bit-period counter (cleared on every state change, wraps per data bit) and data shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if (state_nx != state)         cnt <= '0;
      else if (state == DATA && at_end) cnt <= '0;
      else                           cnt <= cnt + CW'(1);

      if (state == IDLE) bit_idx <= 3'd0;
      else if (state == DATA && at_end) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {rx_s, shreg[7:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  // Even-parity check: data bits XOR parity bit must be zero; cleared at each new start bit.
  always_ff @(posedge clk) begin
    if (rst)                           par_bad <= 1'b0;
    else if (state == START)           par_bad <= 1'b0;
    else if (state == PARITY && at_end) par_bad <= (^shreg) ^ rx_s;
  end

  // Registered parity error pulse.
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= pe_req;
  end

  assign bus.parity_err = parity_err_q;
`else
  assign par_bad        = 1'b0;
  assign bus.parity_err = 1'b0;
`endif

  // FIFO status: extra pointer MSB separates full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && bus.ready;
  assign wr_en   = push_req && (!full || pop);
  assign ovr_req = push_req && full && !pop;

  // FIFO pointers; a push into a full FIFO succeeds only when a pop frees a slot the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // FIFO storage; no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  // Registered frame and overrun error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= fe_req;
      overrun_q   <= ovr_req;
    end
  end

  assign bus.valid     = !empty;
  assign bus.data_out  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level model of the receiver plus FIFO queue, checked every cycle.
// Latency: model applies each frame outcome at the predicted stop-sample cycle.
// Backpressure: ready is driven by directed pops; overrun predicted from the model queue depth.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Cycle in which rx is pulled low -> stop-sample cycle: 2 sync cycles + half bit + 9 (or 10) bits.
  localparam int STOP_OFS = 2 + CPB / 2 + (9 + (PAR_EN ? 1 : 0)) * CPB;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  always #5 clk = ~clk;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         good;
    bit         fe;
    bit         pe;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  ev_t        cur_ev;
  int         cyc = 0;
  bit         started = 1'b0;
  bit         e_fe = 1'b0, e_ov = 1'b0, e_pe = 1'b0;
  bit         m_pop, m_push;
  int         n_chk = 0, n_fail = 0;
  int         fe_seen = 0, ov_seen = 0, pe_seen = 0;
  int         rise_cyc = -1, last_k = 0;
  bit         prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: frame outcomes land at their stop-sample cycle; the FIFO is a plain queue.
  always @(posedge clk) begin
    e_fe = 1'b0; e_ov = 1'b0; e_pe = 1'b0;
    if (rst) begin
      mq.delete();
      evq.delete();
    end else begin
      m_pop  = (mq.size() != 0) && (bus.ready === 1'b1);
      m_push = 1'b0;
      if (evq.size() != 0 && evq[0].at == cyc) begin
        cur_ev = evq.pop_front();
        m_push = cur_ev.good;
        e_fe   = cur_ev.fe;
        e_pe   = cur_ev.pe;
      end
      if (m_push && mq.size() == DEPTH && !m_pop) e_ov = 1'b1;
      if (m_pop) void'(mq.pop_front());
      if (m_push && !e_ov) mq.push_back(cur_ev.b);
    end
    cyc++;
    started = 1'b1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("valid", {31'b0, bus.valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) chk("data_out", {24'b0, bus.data_out}, {24'b0, mq[0]});
      else                chk("data_out", {24'b0, bus.data_out}, 32'h0);
      chk("frame_err",  {31'b0, bus.frame_err},  {31'b0, e_fe});
      chk("overrun",    {31'b0, bus.overrun},    {31'b0, e_ov});
      chk("parity_err", {31'b0, bus.parity_err}, {31'b0, e_pe});
      if (bus.frame_err === 1'b1)  fe_seen++;
      if (bus.overrun === 1'b1)    ov_seen++;
      if (bus.parity_err === 1'b1) pe_seen++;
      if (bus.valid === 1'b1 && !prev_valid) rise_cyc = cyc;
      prev_valid = (bus.valid === 1'b1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
  endtask

  // Transmit one frame and register its expected outcome with the model.
  task automatic send(input logic [7:0] b, input bit stop_hi = 1'b1,
                      input int stop_bits = 1, input bit bad_par = 1'b0);
    ev_t e;
    rx     = 1'b0;
    last_k = cyc;
    e.at   = cyc + STOP_OFS;
    e.b    = b;
    e.pe   = PAR_EN && bad_par;
    e.fe   = !stop_hi;
    e.good = stop_hi && !e.pe;
    evq.push_back(e);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    if (PAR_EN) begin
      rx = (^b) ^ bad_par;
      tick(CPB);
    end
    rx = stop_hi;
    tick(CPB * stop_bits);
    rx = 1'b1;
  endtask

  int fe0, ov0, pe0;

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    bus.ready = 1'b0;
    tick(3);
    chk("reset_valid", {31'b0, bus.valid}, 32'h0);
    chk("reset_data", {24'b0, bus.data_out}, 32'h0);
    rst = 1'b0;
    tick(5);

    // 1: single byte, valid rise timing, single-cycle pop
    send(8'h41);
    tick(10);
    chk("t1_rise_offset", rise_cyc - last_k, PAR_EN ? 171 : 155);
    chk("t1_valid", {31'b0, bus.valid}, 32'h1);
    chk("t1_data", {24'b0, bus.data_out}, 32'h41);
    pop1();
    chk("t1_valid_after_pop", {31'b0, bus.valid}, 32'h0);

    // 2: back-to-back frames
    fe0 = fe_seen; ov0 = ov_seen; pe0 = pe_seen;
    send(8'h41);
    send(8'h42);
    tick(10);
    chk("t2_head0", {24'b0, bus.data_out}, 32'h41);
    pop1();
    chk("t2_head1", {24'b0, bus.data_out}, 32'h42);
    pop1();
    chk("t2_empty", {31'b0, bus.valid}, 32'h0);
    chk("t2_no_errors", fe_seen + ov_seen + pe_seen - fe0 - ov0 - pe0, 0);

    // 3: short glitch rejected, then a real frame
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    chk("t3_no_push", {31'b0, bus.valid}, 32'h0);
    send(8'h55);
    tick(10);
    chk("t3_data", {24'b0, bus.data_out}, 32'h55);
    pop1();

    // 4: framing error with line held low, then recovery
    fe0 = fe_seen;
    send(8'hA5, 1'b0, 2);
    tick(20);
    chk("t4_frame_err_count", fe_seen - fe0, 1);
    chk("t4_no_push", {31'b0, bus.valid}, 32'h0);
    send(8'h3C);
    tick(10);
    chk("t4_data", {24'b0, bus.data_out}, 32'h3C);
    pop1();

    // 5: overrun on fifth byte
    ov0 = ov_seen;
    for (int i = 1; i <= 5; i++) send(8'(i));
    tick(10);
    chk("t5_overrun_count", ov_seen - ov0, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("t5_pop_data", {24'b0, bus.data_out}, i);
      pop1();
    end
    chk("t5_empty", {31'b0, bus.valid}, 32'h0);

    // 6: reset mid-frame with bytes buffered
    send(8'hAA);
    send(8'hBB);
    tick(5);
    chk("t6_buffered", {24'b0, bus.data_out}, 32'hAA);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(30);
    rst = 1'b1;
    tick();
    chk("t6_valid_after_rst", {31'b0, bus.valid}, 32'h0);
    rst = 1'b0;
    tick(200);
    chk("t6_no_spurious", {31'b0, bus.valid}, 32'h0);
    send(8'h12);
    tick(10);
    chk("t6_data", {24'b0, bus.data_out}, 32'h12);
    pop1();

`ifdef UART_RX_PARITY_EN
    pe0 = pe_seen;
    send(8'h12, 1'b1, 1, 1'b1);
    tick(10);
    chk("t6_parity_err_count", pe_seen - pe0, 1);
    chk("t6_parity_no_push", {31'b0, bus.valid}, 32'h0);
`endif

    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
